// File: rtl/countdown_timer.sv
// countdown_timer
//   Count-down companion to the alarm clock. The user sets an hrs:min preset,
//   the block decrements hh:mm:ss once per tick and raises alarm at 00:00:00.
//   After the alarm clears, the count reloads from the preset.
//
// Parameters
//   MAX_HRS      highest settable hour value (hrs wraps MAX_HRS -> 0 in SET)
//   ALARM_TICKS  ticks the alarm stays high before it clears itself
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high; clears all state
//   tick         one-cycle 1 Hz enable
//   set_mode     level, 1 = edit the preset
//   sethrs1min0  field selected for inc: 1 = hrs, 0 = min
//   inc          pulse, increments the selected field while in SET
//   start        pulse, run or resume (ignored when the count is 00:00:00)
//   stop         pulse, pause
//   alarmreset   pulse, acknowledge the alarm
//   sec/min/hrs  current count, binary
//   running      1 while counting
//   alarm        expiry indication
//
// Build option
//   AUTO_RELOAD_EN  when defined, expiry reloads the preset and keeps running
//                   with alarm raised, rather than stopping in an ALARM state.
module countdown_timer #(
    parameter int MAX_HRS     = 23,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       sethrs1min0,
    input  logic       inc,
    input  logic       start,
    input  logic       stop,
    input  logic       alarmreset,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hrs,
    output logic       running,
    output logic       alarm
);

    localparam int ACW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [2:0] {IDLE, SET, RUN, PAUSE, ALARM} state_t;

    state_t         state, state_nxt;
    logic [7:0]     sec_nxt, min_nxt, hrs_nxt;
    logic [7:0]     pre_sec, pre_min, pre_hrs;
    logic [7:0]     pre_sec_nxt, pre_min_nxt, pre_hrs_nxt;
    logic [ACW-1:0] acnt, acnt_nxt;
    logic           alarm_nxt;

    logic [7:0]     dec_sec, dec_min, dec_hrs;
    logic           dec_zero;
    logic           cnt_zero;
    logic           acnt_last;

    // One-second decrement with borrow; hrs is never 0 when the borrow
    // reaches it because 00:00:00 is never counted down.
    always_comb begin
        dec_sec = sec;
        dec_min = min;
        dec_hrs = hrs;
        if (sec != 8'd0) begin
            dec_sec = sec - 8'd1;
        end else if (min != 8'd0) begin
            dec_sec = 8'd59;
            dec_min = min - 8'd1;
        end else begin
            dec_sec = 8'd59;
            dec_min = 8'd59;
            dec_hrs = hrs - 8'd1;
        end
    end

    assign dec_zero  = (hrs == 8'd0) && (min == 8'd0) && (sec == 8'd1);
    assign cnt_zero  = (hrs == 8'd0) && (min == 8'd0) && (sec == 8'd0);
    assign acnt_last = (acnt == ACW'(ALARM_TICKS - 1));

    always_comb begin
        state_nxt   = state;
        sec_nxt     = sec;
        min_nxt     = min;
        hrs_nxt     = hrs;
        pre_sec_nxt = pre_sec;
        pre_min_nxt = pre_min;
        pre_hrs_nxt = pre_hrs;
        acnt_nxt    = acnt;
        alarm_nxt   = alarm;

        case (state)
            IDLE, PAUSE: begin
                if (set_mode) begin
                    state_nxt = SET;
                    sec_nxt   = 8'd0;
                end else if (start && !cnt_zero) begin
                    state_nxt = RUN;
                end
            end

            SET: begin
                if (!set_mode) begin
                    state_nxt   = IDLE;
                    pre_sec_nxt = sec;
                    pre_min_nxt = min;
                    pre_hrs_nxt = hrs;
                end else if (inc) begin
                    if (sethrs1min0)
                        hrs_nxt = (hrs == 8'(MAX_HRS)) ? 8'd0 : hrs + 8'd1;
                    else
                        min_nxt = (min == 8'd59) ? 8'd0 : min + 8'd1;
                end
            end

            RUN: begin
                // alarm can only be high here in the auto-reload build
                if (alarmreset && alarm) begin
                    alarm_nxt = 1'b0;
                end else if (stop) begin
                    state_nxt = PAUSE;
                    alarm_nxt = 1'b0;
                end else if (tick) begin
                    if (dec_zero) begin
                        alarm_nxt = 1'b1;
                        acnt_nxt  = '0;
`ifdef AUTO_RELOAD_EN
                        sec_nxt   = pre_sec;
                        min_nxt   = pre_min;
                        hrs_nxt   = pre_hrs;
`else
                        sec_nxt   = 8'd0;
                        min_nxt   = 8'd0;
                        hrs_nxt   = 8'd0;
                        state_nxt = ALARM;
`endif
                    end else begin
                        sec_nxt = dec_sec;
                        min_nxt = dec_min;
                        hrs_nxt = dec_hrs;
                        if (alarm) begin
                            if (acnt_last)
                                alarm_nxt = 1'b0;
                            else
                                acnt_nxt = acnt + ACW'(1);
                        end
                    end
                end
            end

            ALARM: begin
                if (alarmreset || (tick && acnt_last)) begin
                    state_nxt = IDLE;
                    alarm_nxt = 1'b0;
                    sec_nxt   = pre_sec;
                    min_nxt   = pre_min;
                    hrs_nxt   = pre_hrs;
                end else if (tick) begin
                    acnt_nxt = acnt + ACW'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sec     <= 8'd0;
            min     <= 8'd0;
            hrs     <= 8'd0;
            pre_sec <= 8'd0;
            pre_min <= 8'd0;
            pre_hrs <= 8'd0;
            acnt    <= '0;
            alarm   <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            sec     <= sec_nxt;
            min     <= min_nxt;
            hrs     <= hrs_nxt;
            pre_sec <= pre_sec_nxt;
            pre_min <= pre_min_nxt;
            pre_hrs <= pre_hrs_nxt;
            acnt    <= acnt_nxt;
            alarm   <= alarm_nxt;
            running <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Bench for countdown_timer: directed scenarios followed by random pulses,
//   every cycle compared against a reference model that keeps the count as
//   total seconds.
module tb_countdown_timer;

    localparam int MAX_HRS     = 23;
    localparam int ALARM_TICKS = 10;

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_ALARM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       set_mode = 1'b0;
    logic       sethrs1min0 = 1'b0;
    logic       inc = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       alarmreset = 1'b0;
    logic [7:0] sec, min, hrs;
    logic       running, alarm;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int mst = M_IDLE;
    int mh = 0, mm = 0, ms = 0;
    int ph = 0, pm = 0, ps = 0;
    int mal = 0, macnt = 0;

    countdown_timer #(.MAX_HRS(MAX_HRS), .ALARM_TICKS(ALARM_TICKS)) dut (
        .clk(clk), .reset(reset), .tick(tick), .set_mode(set_mode),
        .sethrs1min0(sethrs1min0), .inc(inc), .start(start), .stop(stop),
        .alarmreset(alarmreset), .sec(sec), .min(min), .hrs(hrs),
        .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int total();
        return mh * 3600 + mm * 60 + ms;
    endfunction

    task automatic set_total(input int t);
        mh = t / 3600;
        mm = (t / 60) % 60;
        ms = t % 60;
    endtask

    task automatic reload();
        mh = ph; mm = pm; ms = ps;
    endtask

    // Next model state from the inputs currently driven.
    task automatic model_step();
        int t;
        if (reset) begin
            mst = M_IDLE; mh = 0; mm = 0; ms = 0; ph = 0; pm = 0; ps = 0;
            mal = 0; macnt = 0;
            return;
        end
        case (mst)
            M_IDLE, M_PAUSE: begin
                if (set_mode) begin mst = M_SET; ms = 0; end
                else if (start && total() != 0) mst = M_RUN;
            end
            M_SET: begin
                if (!set_mode) begin mst = M_IDLE; ph = mh; pm = mm; ps = ms; end
                else if (inc) begin
                    if (sethrs1min0) mh = (mh + 1) % (MAX_HRS + 1);
                    else mm = (mm + 1) % 60;
                end
            end
            M_RUN: begin
                if (alarmreset && mal != 0) mal = 0;
                else if (stop) begin mst = M_PAUSE; mal = 0; end
                else if (tick) begin
                    t = total() - 1;
                    if (t == 0) begin
                        mal = 1; macnt = 0;
`ifdef AUTO_RELOAD_EN
                        reload();
`else
                        set_total(0);
                        mst = M_ALARM;
`endif
                    end else begin
                        set_total(t);
                        if (mal != 0) begin
                            macnt++;
                            if (macnt == ALARM_TICKS) mal = 0;
                        end
                    end
                end
            end
            M_ALARM: begin
                if (tick) macnt++;
                if (alarmreset || macnt == ALARM_TICKS) begin
                    mst = M_IDLE; mal = 0; reload();
                end
            end
            default: mst = M_IDLE;
        endcase
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("sec", int'(sec), ms);
        chk("min", int'(min), mm);
        chk("hrs", int'(hrs), mh);
        chk("running", int'(running), (mst == M_RUN) ? 1 : 0);
        chk("alarm", int'(alarm), mal);
        reset = 0; tick = 0; inc = 0; start = 0; stop = 0; alarmreset = 0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin tick = 1; step(); end
    endtask

    task automatic do_set(input int dm, input int dh);
        set_mode = 1; step();
        repeat (dm) begin sethrs1min0 = 0; inc = 1; step(); end
        repeat (dh) begin sethrs1min0 = 1; inc = 1; step(); end
        set_mode = 0; step();
    endtask

    task automatic chk_count(input string tag, input int h, input int m, input int s);
        chk({tag, "_hms"}, int'(hrs) * 3600 + int'(min) * 60 + int'(sec), h * 3600 + m * 60 + s);
    endtask

    initial begin
        // reset held two cycles
        reset = 1; step();
        reset = 1; step();
        chk_count("reset", 0, 0, 0);
        chk("reset_running", int'(running), 0);
        chk("reset_alarm", int'(alarm), 0);

        // start at 00:00:00 is ignored
        start = 1; step();
        chk("start_zero_running", int'(running), 0);

        // preset 00:02:00 and run
        do_set(2, 0);
        start = 1; step();
        chk_count("run_0200", 0, 2, 0);
        chk("run_0200_running", int'(running), 1);
        ticks(1);
        chk_count("tick_0159", 0, 1, 59);

        // from pause: set 01:00:00 (min wraps 1 -> 0 after 59 incs)
        stop = 1; step();
        do_set(59, 1);
        start = 1; step();
        ticks(1);
        chk_count("borrow_hrs", 0, 59, 59);

        // hrs wraps after MAX_HRS+1 increments; preset 00:01:00
        stop = 1; step();
        set_mode = 1; step();
        repeat (MAX_HRS + 1) begin sethrs1min0 = 1; inc = 1; step(); end
        chk("hrs_wrap", int'(hrs), 0);
        repeat (2) begin sethrs1min0 = 0; inc = 1; step(); end
        set_mode = 0; step();
        start = 1; step();
        ticks(60);
`ifdef AUTO_RELOAD_EN
        chk_count("auto_reload", 0, 1, 0);
        chk("auto_alarm", int'(alarm), 1);
        chk("auto_running", int'(running), 1);
        ticks(ALARM_TICKS);
        chk("auto_alarm_clear", int'(alarm), 0);
        stop = 1; step();
`else
        chk_count("expire", 0, 0, 0);
        chk("expire_alarm", int'(alarm), 1);
        chk("expire_running", int'(running), 0);
        ticks(ALARM_TICKS - 1);
        chk("alarm_held", int'(alarm), 1);
        ticks(1);
        chk("alarm_auto_clear", int'(alarm), 0);
        chk_count("reload", 0, 1, 0);
`endif

        // stop at 00:01:30, ticks ignored, start with coincident tick
        do_set(1, 0);
        start = 1; step();
        ticks(30);
        stop = 1; step();
        ticks(5);
        chk_count("pause_hold", 0, 1, 30);
        start = 1; tick = 1; step();
        chk_count("start_tick", 0, 1, 30);
        chk("start_tick_running", int'(running), 1);
        ticks(1);
        chk_count("resume", 0, 1, 29);

        // reset mid-run
        reset = 1; step();
        chk_count("reset_mid", 0, 0, 0);
        chk("reset_mid_running", int'(running), 0);

        // alarmreset and start together in the alarm phase
        do_set(1, 0);
        start = 1; step();
        ticks(60);
        alarmreset = 1; start = 1; step();
        step();
        chk("ack_alarm", int'(alarm), 0);
`ifndef AUTO_RELOAD_EN
        chk("ack_no_run", int'(running), 0);
        chk_count("ack_reload", 0, 1, 0);
`endif

        // random pulses
        for (int i = 0; i < 4000; i++) begin
            tick        = ($urandom_range(3) == 0);
            inc         = ($urandom_range(3) == 0);
            sethrs1min0 = ($urandom_range(7) == 0);
            start       = ($urandom_range(7) == 0);
            stop        = ($urandom_range(19) == 0);
            alarmreset  = ($urandom_range(39) == 0);
            reset       = ($urandom_range(499) == 0);
            if ($urandom_range(24) == 0) set_mode = ~set_mode;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
